// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the data port, the shared memory bus
// and the stall request of the two-port-to-one memory arbiter.
//   slave  : the arbiter's view. It serves the IF/DM requesters, drives the mem_* bus,
//            and drives stallreq.
//   master : the environment's view. This covers the requesters, the memory and the
//            stall controller.
// Signals:
//   if_req/if_addr -> if_rdata/if_ack                       fetch handshake
//   dm_req/dm_we/dm_addr/dm_wdata/dm_sel -> dm_rdata/dm_ack load/store handshake
//   mem_req/mem_we/mem_addr/mem_wdata/mem_sel -> mem_rdata/mem_ack  bus
//   stallreq                                                pipeline stall request
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_ack;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_sel;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_ack;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_sel;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;

  logic                  stallreq;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_sel,
    output dm_rdata, dm_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
    input  mem_rdata, mem_ack,
    output stallreq
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_sel,
    input  dm_rdata, dm_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
    output mem_rdata, mem_ack,
    input  stallreq
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory bus between instruction fetch (IF,
// read-only) and the MEM stage (DM, load/store). Each transfer runs as a
// req/ack handshake. Read data returns to the owning port with a one-cycle ack.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_if.slave carrying the IF/DM ports, the mem_* bus and stallreq
// Build option:
//   ARB_RR_EN - when defined, simultaneous requests alternate by round robin.
//               When undefined, DM has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  state_e              state_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [SEL_W-1:0]    mem_sel_q;
  logic                if_ack_q;
  logic                dm_ack_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dm_rdata_q;

  logic if_want, dm_want, grant_if, grant_dm;

`ifdef ARB_RR_EN
  // 0 = IF granted last, 1 = DM granted last
  logic last_grant_q;
`endif

  // A port that is being acked this cycle is being retired. Its request must not be re-granted.
  always_comb begin
    if_want  = bus.if_req & ~if_ack_q;
    dm_want  = bus.dm_req & ~dm_ack_q;
`ifdef ARB_RR_EN
    grant_dm = dm_want & (~if_want | ~last_grant_q);
`else
    grant_dm = dm_want;
`endif
    grant_if = if_want & ~grant_dm;
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (grant_dm)      last_grant_q <= 1'b1;
      else if (grant_if) last_grant_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // mem_ack seen here is spurious and is deliberately ignored
          if (grant_dm) begin
            state_q     <= BUSY_DM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            mem_sel_q   <= bus.dm_sel;
          end else if (grant_if) begin
            state_q     <= BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            mem_sel_q   <= '1;
          end
        end
        BUSY_IF: begin
          if (bus.mem_ack) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            if_ack_q   <= 1'b1;
            if_rdata_q <= bus.mem_rdata;
          end
        end
        BUSY_DM: begin
          if (bus.mem_ack) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            dm_ack_q   <= 1'b1;
            dm_rdata_q <= bus.mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.stallreq  = (bus.if_req & ~if_ack_q) | (bus.dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (either ARB_RR_EN setting).
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_dm;
    logic [31:0] data;
  } ack_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  sel;
    bit          chk_wdata;
  } gnt_t;

  ack_t ack_q[$];
  gnt_t gnt_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- memory model ----------------
  int   mem_wait   = 0;
  bit   manual     = 1'b0;
  logic manual_ack = 1'b0;
  int   wcnt       = 0;

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    case (a)
      32'h0000_0004: return 32'h0010_0093;
      32'h0000_0008: return 32'h0020_0113;
      32'h0000_0200: return 32'hCAFE_F00D;
      default:       return a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  always @(negedge clk) begin
    if (manual) begin
      bus.mem_ack   = manual_ack;
      bus.mem_rdata = 32'h1234_5678;
      wcnt          = 0;
    end else if (bus.mem_req) begin
      if (wcnt >= mem_wait) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata_for(bus.mem_addr);
        wcnt          = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0BAD_0BAD;
      wcnt          = 0;
    end
  end

  // ---------------- monitor ----------------
  logic prev_req = 1'b0;
  gnt_t cur;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.if_ack && bus.dm_ack) fail_now("both_acks_same_cycle");
      if (bus.if_ack || bus.dm_ack) begin
        if (ack_q.size() == 0) begin
          fail_now("unexpected_ack");
        end else begin
          ack_t e;
          e = ack_q.pop_front();
          chk("ack_port_is_dm", bus.dm_ack, e.is_dm);
          chk("ack_rdata", bus.dm_ack ? bus.dm_rdata : bus.if_rdata, e.data);
        end
      end
      if (bus.mem_req && !prev_req) begin
        if (gnt_q.size() == 0) begin
          fail_now("unexpected_grant");
        end else begin
          cur = gnt_q.pop_front();
          chk("grant_addr", bus.mem_addr, cur.addr);
          chk("grant_we", bus.mem_we, cur.we);
          chk("grant_sel", bus.mem_sel, cur.sel);
          if (cur.chk_wdata) chk("grant_wdata", bus.mem_wdata, cur.wdata);
        end
      end else if (bus.mem_req) begin
        chk("stable_addr", bus.mem_addr, cur.addr);
        chk("stable_we", bus.mem_we, cur.we);
        chk("stable_sel", bus.mem_sel, cur.sel);
        if (cur.chk_wdata) chk("stable_wdata", bus.mem_wdata, cur.wdata);
      end
      prev_req = bus.mem_req;
    end else begin
      prev_req = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Requester keeps x_req high across the edge that closes its ack cycle.
  task automatic wait_ack(input bit dm, input bit chk_stall);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (dm ? bus.dm_ack : bus.if_ack) begin
        seen = 1'b1;
        if (chk_stall) chk("stallreq_ack_cycle", bus.stallreq, 1'b0);
        break;
      end else if (chk_stall) begin
        chk("stallreq_waiting", bus.stallreq, 1'b1);
      end
    end
    if (!seen) fail_now(dm ? "dm_ack_timeout" : "if_ack_timeout");
    @(posedge clk);
    #1;
    if (dm) bus.dm_req = 1'b0;
    else    bus.if_req = 1'b0;
  endtask

  task automatic push_if(input logic [31:0] addr, input logic [31:0] rdata);
    gnt_q.push_back('{addr: addr, we: 1'b0, wdata: 32'h0, sel: 4'hF, chk_wdata: 1'b0});
    ack_q.push_back('{is_dm: 1'b0, data: rdata});
  endtask

  task automatic push_dm(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] sel, input logic [31:0] rdata);
    gnt_q.push_back('{addr: addr, we: we, wdata: wdata, sel: sel, chk_wdata: 1'b1});
    ack_q.push_back('{is_dm: 1'b1, data: rdata});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus.dm_sel   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_sel", bus.mem_sel, 4'h0);
    chk("rst_if_ack", bus.if_ack, 1'b0);
    chk("rst_dm_ack", bus.dm_ack, 1'b0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
    chk("rst_stallreq", bus.stallreq, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Spurious mem_ack in IDLE with no requests
    manual     = 1'b1;
    manual_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("spur_mem_req", bus.mem_req, 1'b0);
      chk("spur_if_ack", bus.if_ack, 1'b0);
      chk("spur_dm_ack", bus.dm_ack, 1'b0);
      chk("spur_if_rdata", bus.if_rdata, 32'h0);
      chk("spur_dm_rdata", bus.dm_rdata, 32'h0);
      chk("spur_stallreq", bus.stallreq, 1'b0);
    end
    manual_ack = 1'b0;
    manual     = 1'b0;

    // Zero-wait fetch from 0x4
    @(posedge clk); #1;
    mem_wait = 0;
    push_if(32'h4, 32'h0010_0093);
    bus.if_addr = 32'h4;
    bus.if_req  = 1'b1;
    wait_ack(1'b0, 1'b1);

    // Store with 3 wait states; rdata is whatever the bus returned
    mem_wait = 3;
    push_dm(32'h100, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'h5A5A_5B5A);
    bus.dm_addr  = 32'h100;
    bus.dm_we    = 1'b1;
    bus.dm_wdata = 32'hDEAD_BEEF;
    bus.dm_sel   = 4'h3;
    bus.dm_req   = 1'b1;
    wait_ack(1'b1, 1'b1);
    bus.dm_we    = 1'b0;
    bus.dm_wdata = 32'h0;
    chk("if_rdata_hold", bus.if_rdata, 32'h0010_0093);

    // Simultaneous fetch 0x8 and load 0x200
    mem_wait = 1;
`ifdef ARB_RR_EN
    push_if(32'h8, 32'h0020_0113);
    push_dm(32'h200, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D);
`else
    push_dm(32'h200, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D);
    push_if(32'h8, 32'h0020_0113);
`endif
    bus.if_addr = 32'h8;
    bus.dm_addr = 32'h200;
    bus.dm_sel  = 4'hF;
    bus.if_req  = 1'b1;
    bus.dm_req  = 1'b1;
    fork
      wait_ack(1'b1, 1'b0);
      wait_ack(1'b0, 1'b0);
    join

    // Fetch with 2 wait states from 0xC
    mem_wait = 2;
    push_if(32'hC, 32'h5A5A_5A56);
    bus.if_addr = 32'hC;
    bus.if_req  = 1'b1;
    wait_ack(1'b0, 1'b1);

    // Reset during BUSY_DM; the transfer is dropped without an ack
    manual     = 1'b1;
    manual_ack = 1'b0;
    gnt_q.push_back('{addr: 32'h300, we: 1'b1, wdata: 32'h1111_2222, sel: 4'hC, chk_wdata: 1'b1});
    bus.dm_addr  = 32'h300;
    bus.dm_we    = 1'b1;
    bus.dm_wdata = 32'h1111_2222;
    bus.dm_sel   = 4'hC;
    bus.dm_req   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_mem_req", bus.mem_req, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", bus.mem_req, 1'b0);
    chk("async_rst_mem_we", bus.mem_we, 1'b0);
    chk("async_rst_mem_addr", bus.mem_addr, 32'h0);
    chk("async_rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("async_rst_mem_sel", bus.mem_sel, 4'h0);
    chk("async_rst_if_rdata", bus.if_rdata, 32'h0);
    chk("async_rst_dm_rdata", bus.dm_rdata, 32'h0);
    #1;
    rst        = 1'b0;
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    manual_ack = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_rst_dm_ack", bus.dm_ack, 1'b0);
      chk("post_rst_mem_req", bus.mem_req, 1'b0);
    end
    manual_ack = 1'b0;
    manual     = 1'b0;

    // Fetch after reset still works
    mem_wait = 0;
    push_if(32'h4, 32'h0010_0093);
    bus.if_addr = 32'h4;
    bus.if_req  = 1'b1;
    wait_ack(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("if_rdata_hold_final", bus.if_rdata, 32'h0010_0093);
    chk("final_mem_req", bus.mem_req, 1'b0);

    chk("ack_queue_empty", ack_q.size(), 32'd0);
    chk("grant_queue_empty", gnt_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
